// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the single-port data RAM between
// the CPU load/store path (C) and the debug/loader port (D). Each access runs
// IDLE -> ISSUE -> RESP; back-to-back grants to the other requester skip IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  // Requester select encoding: 0 = C, 1 = D.
  state_t state, nxt;
  logic   owner, ptr;
  logic   grant, gsel;
  mreq_t  c_r, d_r, g_r;

  assign c_r = '{we: c_we, addr: c_addr, wdata: c_wdata};
  assign d_r = '{we: d_we, addr: d_addr, wdata: d_wdata};
  assign g_r = gsel ? d_r : c_r;

  // Next-state and grant decision; the owner's own req is ignored in RESP.
  always_comb begin
    nxt   = state;
    grant = 1'b0;
    gsel  = owner;
    case (state)
      IDLE: begin
        if (c_req || d_req) begin
          grant = 1'b1;
          gsel  = (c_req && d_req) ? ptr : d_req;
          nxt   = ISSUE;
        end
      end
      ISSUE: nxt = RESP;
      RESP: begin
        if (owner ? c_req : d_req) begin
          grant = 1'b1;
          gsel  = ~owner;
          nxt   = ISSUE;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, owner, pointer and registered RAM command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      if (state == RESP) ptr <= ~owner;
      if (grant) begin
        owner     <= gsel;
        mem_addr  <= g_r.addr;
        mem_we    <= g_r.we;
        mem_wdata <= g_r.wdata;
      end else if (state == ISSUE) begin
        mem_we <= 1'b0;
      end
    end
  end

  // Acks and read data come straight from state so reset kills them at once.
  always_comb begin
    busy    = (state != IDLE);
    c_ack   = (state == RESP) && !owner;
    d_ack   = (state == RESP) && owner;
    rd_data = (state == RESP) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a behavioural synchronous RAM.
module tb_mem_arbiter;
  localparam int AW = 16, DW = 16;

  logic          clk = 0, rst = 1;
  logic          c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] c_addr = 0, d_addr = 0;
  logic [DW-1:0] c_wdata = 0, d_wdata = 0;
  logic          c_ack, d_ack, mem_we, busy;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ram [0:255];
  int vec = 0, errs = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic test_reset;
    #1;
    vec++; if ({c_ack, d_ack, busy, mem_we} !== 4'b0) begin errs++;
      $display("FAIL reset_ctl got %b want 0000", {c_ack, d_ack, busy, mem_we}); end
    vec++; if ({mem_addr, mem_wdata, rd_data} !== '0) begin errs++;
      $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, rd_data}); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single_read;
    ram[5] = 16'h00A5;
    c_req = 1; c_we = 0; c_addr = 5;
    @(negedge clk);
    vec++; if ({busy, mem_we, c_ack, d_ack} !== 4'b1000 || mem_addr !== 16'd5) begin errs++;
      $display("FAIL rd_issue got ctl=%b addr=%h want 1000 addr=0005", {busy, mem_we, c_ack, d_ack}, mem_addr); end
    @(negedge clk);
    vec++; if ({c_ack, d_ack} !== 2'b10 || rd_data !== 16'h00A5) begin errs++;
      $display("FAIL rd_ack got acks=%b data=%h want 10 00a5", {c_ack, d_ack}, rd_data); end
    c_req = 0;
    @(negedge clk);
    vec++; if ({busy, c_ack, d_ack} !== 3'b000) begin errs++;
      $display("FAIL rd_done got %b want 000", {busy, c_ack, d_ack}); end
  endtask

  task automatic test_write_then_read;
    d_req = 1; d_we = 1; d_addr = 3; d_wdata = 16'h1234;
    @(negedge clk);
    vec++; if (mem_we !== 1'b1 || mem_addr !== 16'd3 || mem_wdata !== 16'h1234) begin errs++;
      $display("FAIL wr_issue got we=%b a=%h d=%h want 1 0003 1234", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    vec++; if (d_ack !== 1'b1 || c_ack !== 1'b0 || mem_we !== 1'b0) begin errs++;
      $display("FAIL wr_ack got d=%b c=%b we=%b want 1 0 0", d_ack, c_ack, mem_we); end
    d_req = 0; d_we = 0;
    c_req = 1; c_we = 0; c_addr = 3;
    @(negedge clk);
    vec++; if (busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'd3) begin errs++;
      $display("FAIL b2b_issue got busy=%b we=%b a=%h want 1 0 0003", busy, mem_we, mem_addr); end
    @(negedge clk);
    vec++; if (c_ack !== 1'b1 || rd_data !== 16'h1234) begin errs++;
      $display("FAIL wr_readback got ack=%b data=%h want 1 1234", c_ack, rd_data); end
    c_req = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n = 0, cyc = 0, last = 0;
    logic want_d = 0;
    ram[10] = 16'hC0C0; ram[11] = 16'hD0D0;
    rst = 1; #1; rst = 0;
    @(negedge clk);
    c_req = 1; c_addr = 10; d_req = 1; d_addr = 11;
    while (n < 8 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (c_ack && d_ack) begin vec++; errs++; $display("FAIL both_ack at cycle %0d", cyc); end
      if (c_ack || d_ack) begin
        vec++; if (d_ack !== want_d || rd_data !== (want_d ? 16'hD0D0 : 16'hC0C0)) begin errs++;
          $display("FAIL rr_order ack %0d got d=%b data=%h want d=%b", n, d_ack, rd_data, want_d); end
        vec++; if (cyc - last !== 2) begin errs++;
          $display("FAIL rr_gap ack %0d got %0d cycles want 2", n, cyc - last); end
        last = cyc; want_d = ~want_d; n++;
      end
    end
    vec++; if (n !== 8) begin errs++; $display("FAIL rr_count got %0d acks want 8", n); end
    c_req = 0; d_req = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_owner_held;
    c_req = 1; c_addr = 5;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      vec++; if (c_ack !== (k % 3 == 2) || busy !== (k % 3 != 0) || d_ack !== 1'b0) begin errs++;
        $display("FAIL held k=%0d got ack=%b busy=%b want %b %b", k, c_ack, busy, k % 3 == 2, k % 3 != 0); end
    end
    c_req = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    d_req = 1; d_we = 1; d_addr = 20; d_wdata = 16'hBEEF;
    @(negedge clk);
    vec++; if (mem_we !== 1'b1 || busy !== 1'b1) begin errs++;
      $display("FAIL rmw_issue got we=%b busy=%b want 1 1", mem_we, busy); end
    #2 rst = 1; #1;
    vec++; if ({mem_we, busy, d_ack} !== 3'b000) begin errs++;
      $display("FAIL rmw_async got %b want 000", {mem_we, busy, d_ack}); end
    d_req = 0; d_we = 0;
    @(negedge clk); @(negedge clk);
    vec++; if (d_ack !== 1'b0) begin errs++; $display("FAIL rmw_noack got %b want 0", d_ack); end
    rst = 0;
    ram[21] = 16'h2121; ram[22] = 16'h2222;
    c_req = 1; c_we = 0; c_addr = 21; d_req = 1; d_addr = 22;
    @(negedge clk); @(negedge clk);
    vec++; if (c_ack !== 1'b1 || d_ack !== 1'b0 || rd_data !== 16'h2121) begin errs++;
      $display("FAIL rmw_ptr got c=%b d=%b data=%h want 1 0 2121", c_ack, d_ack, rd_data); end
    c_req = 0;
    @(negedge clk); @(negedge clk);
    vec++; if (d_ack !== 1'b1 || rd_data !== 16'h2222) begin errs++;
      $display("FAIL rmw_d got d=%b data=%h want 1 2222", d_ack, rd_data); end
    d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_input_change;
    ram[7] = 16'h0777; ram[9] = 16'h0999;
    c_req = 1; c_we = 0; c_addr = 7;
    @(negedge clk);
    c_addr = 9;
    #1;
    vec++; if (mem_addr !== 16'd7) begin errs++;
      $display("FAIL chg_addr got %h want 0007", mem_addr); end
    @(negedge clk);
    vec++; if (c_ack !== 1'b1 || rd_data !== 16'h0777) begin errs++;
      $display("FAIL chg_data got ack=%b data=%h want 1 0777", c_ack, rd_data); end
    c_req = 0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    test_reset;
    test_single_read;
    test_write_then_read;
    test_back_to_back;
    test_owner_held;
    test_reset_mid_write;
    test_input_change;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
